// File: rtl/data_mem_rv.sv
// Word-organised data memory for an RV32I core: byte/half/word loads and stores,
// configurable wait states, one-cycle Ready pulse and a post-reset clearing sweep.
module data_mem_rv #(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  Funct3,
   input  logic [31:0] MemSum,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Ready,
   output logic        Busy,
   output logic [1:0]  ErrCode
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {CLEAR, IDLE, WAIT, DONE} state_t;

   state_t        state, state_nx;
   logic [AW-1:0] clr_idx;
   logic [2:0]    wait_cnt;
   logic          lat_read, lat_write;
   logic [2:0]    lat_f3;
   logic [31:0]   lat_addr, lat_wdata;
   logic [31:0]   mem [DEPTH];

   logic          accept, enter_done, commit;
   logic          cur_read, cur_write;
   logic [2:0]    cur_f3;
   logic [31:0]   cur_addr;
   logic          illegal, range_err, misalign;
   logic [1:0]    err;
   logic [31:0]   rd_word, load_val;
   logic [7:0]    rd_byte;
   logic [15:0]   rd_half;
   logic [3:0]    lane_en;
   logic [31:0]   wdata_rep;

   assign accept = (state == IDLE) && (MemRead || MemWrite);

   // With LATENCY=0 DONE is entered on the acceptance edge itself, so the
   // live inputs stand in for the latched copy while still in IDLE.
   always_comb begin
      if (state == IDLE) begin
         cur_read  = MemRead;
         cur_write = MemWrite;
         cur_f3    = Funct3;
         cur_addr  = MemSum;
      end else begin
         cur_read  = lat_read;
         cur_write = lat_write;
         cur_f3    = lat_f3;
         cur_addr  = lat_addr;
      end
   end

   always_comb begin
      illegal = cur_read && cur_write;
      case (cur_f3)
         3'b000, 3'b001, 3'b010: ;
         3'b100, 3'b101:         if (cur_write) illegal = 1'b1;
         default:                illegal = 1'b1;
      endcase
      range_err = {2'b00, cur_addr[31:2]} >= 32'(DEPTH);
      misalign  = ((cur_f3[1:0] == 2'b01) && cur_addr[0]) ||
                  ((cur_f3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
      if (illegal)        err = 2'b11;
      else if (range_err) err = 2'b10;
      else if (misalign)  err = 2'b01;
      else                err = 2'b00;
   end

   always_comb begin
      rd_word = mem[cur_addr[AW+1:2]];
      rd_byte = rd_word[8*cur_addr[1:0] +: 8];
      rd_half = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
      case (cur_f3)
         3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
         3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
         3'b010:  load_val = rd_word;
         3'b100:  load_val = {24'd0, rd_byte};
         3'b101:  load_val = {16'd0, rd_half};
         default: load_val = '0;
      endcase
   end

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      state_nx = state;
      case (state)
         CLEAR: if (clr_idx == AW'(DEPTH - 1)) state_nx = IDLE;
         IDLE:  if (accept) state_nx = (LATENCY == 0) ? DONE : WAIT;
         WAIT:  if (wait_cnt == 3'd0) state_nx = DONE;
         DONE:  state_nx = IDLE;
         default: state_nx = CLEAR;
      endcase
   end

   assign enter_done = (state_nx == DONE) && (state != DONE);
   assign commit     = (state == DONE) && lat_write && (err == 2'b00);
   assign Busy       = (state != IDLE);
   assign Ready      = (state == DONE);
   assign ErrCode    = (state == DONE) ? err : 2'b00;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= CLEAR;
         clr_idx   <= '0;
         wait_cnt  <= '0;
         lat_read  <= 1'b0;
         lat_write <= 1'b0;
         lat_f3    <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         ReadData  <= '0;
      end else begin
         state <= state_nx;
         if (state == CLEAR) clr_idx <= clr_idx + AW'(1);
         if (accept) begin
            lat_read  <= MemRead;
            lat_write <= MemWrite;
            lat_f3    <= Funct3;
            lat_addr  <= MemSum;
            lat_wdata <= WriteData;
            wait_cnt  <= 3'(LATENCY - 1);
         end else if (state == WAIT) begin
            wait_cnt <= wait_cnt - 3'd1;
         end
         if (enter_done) begin
            if (err != 2'b00) ReadData <= '0;
            else if (cur_read) ReadData <= load_val;
         end
      end
   end

   always_comb begin
      case (lat_f3[1:0])
         2'b00:   begin lane_en = 4'b0001 << lat_addr[1:0];              wdata_rep = {4{lat_wdata[7:0]}};  end
         2'b01:   begin lane_en = lat_addr[1] ? 4'b1100 : 4'b0011;       wdata_rep = {2{lat_wdata[15:0]}}; end
         2'b10:   begin lane_en = 4'b1111;                               wdata_rep = lat_wdata;            end
         default: begin lane_en = 4'b0000;                               wdata_rep = lat_wdata;            end
      endcase
   end

   // NOTE: the array itself has no reset; the CLEAR sweep zeroes it one word per cycle instead.
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[clr_idx] <= '0;
      end else if (commit) begin
         for (int b = 0; b < 4; b++)
            if (lane_en[b]) mem[lat_addr[AW+1:2]][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
   end
endmodule
